// File: rtl/csr_reg.sv
// Machine-mode CSR file for tiny_riscv. It serves decode-stage and trap-controller reads,
// takes execute and trap write-backs, and holds the 64-bit cycle and instret counters.
module csr_reg #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] MHARTID_VAL = 32'h0000_0000,
  parameter logic [31:0] MISA_VAL    = 32'h4000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] raddr_i,
  output logic [31:0] rdata_o,
  input  logic        we_i,
  input  logic [31:0] waddr_i,
  input  logic [31:0] wdata_i,
  input  logic        trap_we_i,
  input  logic [31:0] trap_waddr_i,
  input  logic [31:0] trap_wdata_i,
  input  logic [31:0] trap_raddr_i,
  output logic [31:0] trap_rdata_o,
  input  logic        instret_inc_i,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic [31:0] mstatus_o,
  output logic        global_int_en_o
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  logic [31:0] mstatus, mie, mtvec, mscratch, mepc, mcause;
  logic [63:0] mcycle, minstret;
  logic [31:0] mstatus_n, mie_n, mtvec_n, mscratch_n, mepc_n, mcause_n;
  logic [63:0] mcycle_n, minstret_n;

  logic        cyc_lo_wr, cyc_hi_wr, ir_lo_wr, ir_hi_wr;
  logic [31:0] cyc_lo_w, cyc_hi_w, ir_lo_w, ir_hi_w;
  logic        cyc_carry, ir_carry;

  logic [1:0]  wen;
  logic [11:0] wad [2];
  logic [31:0] wdt [2];
  logic [11:0] ra, tra;

  // Port 1 is the trap controller; applying it last lets it win same-address collisions.
  assign wen    = {trap_we_i, we_i};
  assign wad[0] = waddr_i[11:0];
  assign wad[1] = trap_waddr_i[11:0];
  assign wdt[0] = wdata_i;
  assign wdt[1] = trap_wdata_i;
  assign ra     = raddr_i[11:0];
  assign tra    = trap_raddr_i[11:0];

  always_comb begin
    mstatus_n  = mstatus;
    mie_n      = mie;
    mtvec_n    = mtvec;
    mscratch_n = mscratch;
    mepc_n     = mepc;
    mcause_n   = mcause;
    cyc_lo_wr  = 1'b0;
    cyc_hi_wr  = 1'b0;
    ir_lo_wr   = 1'b0;
    ir_hi_wr   = 1'b0;
    cyc_lo_w   = '0;
    cyc_hi_w   = '0;
    ir_lo_w    = '0;
    ir_hi_w    = '0;
    for (int p = 0; p < 2; p++) begin
      if (wen[p]) begin
        case (wad[p])
          A_MSTATUS:   mstatus_n  = wdt[p];
          A_MIE:       mie_n      = wdt[p];
          A_MTVEC:     mtvec_n    = wdt[p];
          A_MSCRATCH:  mscratch_n = wdt[p];
          A_MEPC:      mepc_n     = wdt[p];
          A_MCAUSE:    mcause_n   = wdt[p];
          A_MCYCLE:    begin cyc_lo_wr = 1'b1; cyc_lo_w = wdt[p]; end
          A_MCYCLEH:   begin cyc_hi_wr = 1'b1; cyc_hi_w = wdt[p]; end
          A_MINSTRET:  begin ir_lo_wr  = 1'b1; ir_lo_w  = wdt[p]; end
          A_MINSTRETH: begin ir_hi_wr  = 1'b1; ir_hi_w  = wdt[p]; end
          default: ;
        endcase
      end
    end

    // A written low half never carries into the high half.
    if (cyc_lo_wr) begin
      mcycle_n[31:0] = cyc_lo_w;
      cyc_carry      = 1'b0;
    end else begin
      mcycle_n[31:0] = mcycle[31:0] + 32'd1;
      cyc_carry      = &mcycle[31:0];
    end
    mcycle_n[63:32] = cyc_hi_wr ? cyc_hi_w : mcycle[63:32] + {31'd0, cyc_carry};

    if (ir_lo_wr) begin
      minstret_n[31:0] = ir_lo_w;
      ir_carry         = 1'b0;
    end else begin
      minstret_n[31:0] = minstret[31:0] + {31'd0, instret_inc_i};
      ir_carry         = instret_inc_i & (&minstret[31:0]);
    end
    minstret_n[63:32] = ir_hi_wr ? ir_hi_w : minstret[63:32] + {31'd0, ir_carry};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus  <= '0;
      mie      <= '0;
      mtvec    <= MTVEC_RESET;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      mstatus  <= mstatus_n;
      mie      <= mie_n;
      mtvec    <= mtvec_n;
      mscratch <= mscratch_n;
      mepc     <= mepc_n;
      mcause   <= mcause_n;
      mcycle   <= mcycle_n;
      minstret <= minstret_n;
    end
  end

  function automatic logic [31:0] csr_value(input logic [11:0] a);
    case (a)
      A_MSTATUS:                csr_value = mstatus;
      A_MISA:                   csr_value = MISA_VAL;
      A_MIE:                    csr_value = mie;
      A_MTVEC:                  csr_value = mtvec;
      A_MSCRATCH:               csr_value = mscratch;
      A_MEPC:                   csr_value = mepc;
      A_MCAUSE:                 csr_value = mcause;
      A_MCYCLE,   A_CYCLE:      csr_value = mcycle[31:0];
      A_MCYCLEH,  A_CYCLEH:     csr_value = mcycle[63:32];
      A_MINSTRET, A_INSTRET:    csr_value = minstret[31:0];
      A_MINSTRETH, A_INSTRETH:  csr_value = minstret[63:32];
      A_MHARTID:                csr_value = MHARTID_VAL;
      default:                  csr_value = '0;
    endcase
  endfunction

  function automatic logic writable(input logic [11:0] a);
    writable = a inside {A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE,
                         A_MCYCLE, A_MCYCLEH, A_MINSTRET, A_MINSTRETH};
  endfunction

  always_comb begin
    rdata_o = csr_value(ra);
    if (writable(ra)) begin
      if (we_i && wad[0] == ra)      rdata_o = wdata_i;
      if (trap_we_i && wad[1] == ra) rdata_o = trap_wdata_i;
    end
  end

  always_comb begin
    trap_rdata_o = csr_value(tra);
    if (writable(tra)) begin
      if (we_i && wad[0] == tra)      trap_rdata_o = wdata_i;
      if (trap_we_i && wad[1] == tra) trap_rdata_o = trap_wdata_i;
    end
  end

  assign mtvec_o         = mtvec;
  assign mepc_o          = mepc;
  assign mstatus_o       = mstatus;
  assign global_int_en_o = mstatus[3];

endmodule

// File: tb/tb_csr_reg.sv
// Directed bench for csr_reg: a table of single-cycle vectors for decode, bypass and
// write arbitration, plus hand sequences for the counters and mid-operation reset.
module tb_csr_reg;

  localparam logic [31:0] MTVEC_RST = 32'h0000_1000;
  localparam logic [31:0] MISA      = 32'h4000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] raddr, rdata, waddr, wdata, trap_waddr, trap_wdata, trap_raddr, trap_rdata;
  logic        we, trap_we, instret_inc, global_int_en;
  logic [31:0] mtvec, mepc, mstatus;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  csr_reg #(.MTVEC_RESET(MTVEC_RST)) dut (
    .clk(clk), .rst(rst),
    .raddr_i(raddr), .rdata_o(rdata),
    .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .trap_we_i(trap_we), .trap_waddr_i(trap_waddr), .trap_wdata_i(trap_wdata),
    .trap_raddr_i(trap_raddr), .trap_rdata_o(trap_rdata),
    .instret_inc_i(instret_inc),
    .mtvec_o(mtvec), .mepc_o(mepc), .mstatus_o(mstatus),
    .global_int_en_o(global_int_en)
  );

  typedef struct {
    logic        we;
    logic [31:0] wa, wd;
    logic        twe;
    logic [31:0] ta, td, ra, tra;
    logic [31:0] e_rd, e_trd, e_mtvec, e_mepc, e_mstatus;
    logic        e_gie;
  } vec_t;

  vec_t vt[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %08h expected %08h", name, act, exp);
    else passed++;
  endtask

  task automatic clr_in();
    we = 0; waddr = 0; wdata = 0;
    trap_we = 0; trap_waddr = 0; trap_wdata = 0;
    instret_inc = 0;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr_in();
    rst = 1; raddr = 32'hB00; trap_raddr = 32'hC00;

    // Reset, then the cycle counter counts up from zero.
    next_cyc();
    next_cyc();
    rst = 0;
    @(negedge clk);
    chk("rst_mtvec", mtvec, MTVEC_RST);
    chk("rst_mepc", mepc, 0);
    chk("rst_mstatus", mstatus, 0);
    chk("rst_gie", {31'd0, global_int_en}, 0);
    chk("mcycle_0", rdata, 0);
    chk("cycle_alias_0", trap_rdata, 0);
    next_cyc();
    @(negedge clk);
    chk("mcycle_1", rdata, 1);
    next_cyc();
    @(negedge clk);
    chk("mcycle_2", rdata, 2);
    chk("cycle_alias_2", trap_rdata, 2);
    next_cyc();

    //          we  wa             wd            twe ta        td            ra             tra       rd            trd           mtvec         mepc          mstatus       gie
    vt[0]  = '{0, 0,             0,            0, 0,        0,            32'h301,       32'hF14,  MISA,         0,            MTVEC_RST,    0,            0,            0};
    vt[1]  = '{0, 0,             0,            0, 0,        0,            32'h7C0,       32'h305,  0,            MTVEC_RST,    MTVEC_RST,    0,            0,            0};
    vt[2]  = '{1, 32'h305,       32'h80000100, 0, 0,        0,            32'h305,       32'h305,  32'h80000100, 32'h80000100, MTVEC_RST,    0,            0,            0};
    vt[3]  = '{1, 32'h341,       32'h11111111, 1, 32'h341,  32'h22222222, 32'h341,       32'h341,  32'h22222222, 32'h22222222, 32'h80000100, 0,            0,            0};
    vt[4]  = '{1, 32'h300,       32'h00000008, 1, 32'h342,  32'h000000AB, 32'h342,       32'h300,  32'h000000AB, 32'h00000008, 32'h80000100, 32'h22222222, 0,            0};
    vt[5]  = '{0, 0,             0,            0, 0,        0,            32'h342,       32'h300,  32'h000000AB, 32'h00000008, 32'h80000100, 32'h22222222, 32'h8,        1};
    vt[6]  = '{1, 32'hFFFFF340,  32'hDEADBEEF, 0, 0,        0,            32'h00012340,  32'h340,  32'hDEADBEEF, 32'hDEADBEEF, 32'h80000100, 32'h22222222, 32'h8,        1};
    vt[7]  = '{0, 0,             0,            0, 0,        0,            32'h340,       32'h304,  32'hDEADBEEF, 0,            32'h80000100, 32'h22222222, 32'h8,        1};
    vt[8]  = '{1, 32'h301,       32'h00001234, 1, 32'hF14,  32'h5,        32'h301,       32'hF14,  MISA,         0,            32'h80000100, 32'h22222222, 32'h8,        1};
    vt[9]  = '{0, 0,             0,            0, 0,        0,            32'h301,       32'hF14,  MISA,         0,            32'h80000100, 32'h22222222, 32'h8,        1};
    vt[10] = '{1, 32'h7C0,       32'h77,       0, 0,        0,            32'h7C0,       32'h7C0,  0,            0,            32'h80000100, 32'h22222222, 32'h8,        1};
    vt[11] = '{1, 32'h300,       32'h0,        1, 32'h304,  32'h888,      32'h304,       32'h300,  32'h888,      0,            32'h80000100, 32'h22222222, 32'h8,        1};
    vt[12] = '{0, 0,             0,            0, 0,        0,            32'h304,       32'h300,  32'h888,      0,            32'h80000100, 32'h22222222, 0,            0};
    vt[13] = '{0, 0,             0,            1, 32'h300,  32'hFFFFFFF7, 32'h300,       32'h305,  32'hFFFFFFF7, 32'h80000100, 32'h80000100, 32'h22222222, 0,            0};
    vt[14] = '{0, 0,             0,            0, 0,        0,            32'h300,       32'h341,  32'hFFFFFFF7, 32'h22222222, 32'h80000100, 32'h22222222, 32'hFFFFFFF7, 0};

    for (int i = 0; i < 15; i++) begin
      we = vt[i].we; waddr = vt[i].wa; wdata = vt[i].wd;
      trap_we = vt[i].twe; trap_waddr = vt[i].ta; trap_wdata = vt[i].td;
      raddr = vt[i].ra; trap_raddr = vt[i].tra;
      @(negedge clk);
      chk($sformatf("v%0d_rdata", i), rdata, vt[i].e_rd);
      chk($sformatf("v%0d_trap_rdata", i), trap_rdata, vt[i].e_trd);
      chk($sformatf("v%0d_mtvec", i), mtvec, vt[i].e_mtvec);
      chk($sformatf("v%0d_mepc", i), mepc, vt[i].e_mepc);
      chk($sformatf("v%0d_mstatus", i), mstatus, vt[i].e_mstatus);
      chk($sformatf("v%0d_gie", i), {31'd0, global_int_en}, {31'd0, vt[i].e_gie});
      next_cyc();
    end
    clr_in();

    // mcycle: both halves written together, then low-half carry.
    we = 1; waddr = 32'hB00; wdata = 32'hFFFF_FFFE;
    trap_we = 1; trap_waddr = 32'hB80; trap_wdata = 32'h5;
    raddr = 32'hB00; trap_raddr = 32'hB80;
    next_cyc();
    clr_in();
    @(negedge clk);
    chk("mcyc_w_lo", rdata, 32'hFFFF_FFFE);
    chk("mcyc_w_hi", trap_rdata, 5);
    next_cyc();
    @(negedge clk);
    chk("mcyc_inc_lo", rdata, 32'hFFFF_FFFF);
    chk("mcyc_inc_hi", trap_rdata, 5);
    next_cyc();
    raddr = 32'hC00; trap_raddr = 32'hC80;
    @(negedge clk);
    chk("mcyc_carry_lo", rdata, 0);
    chk("mcyc_carry_hi", trap_rdata, 6);
    next_cyc();

    // Full 64-bit wrap.
    we = 1; waddr = 32'hB00; wdata = 32'hFFFF_FFFF;
    trap_we = 1; trap_waddr = 32'hB80; trap_wdata = 32'hFFFF_FFFF;
    raddr = 32'hB00; trap_raddr = 32'hB80;
    next_cyc();
    clr_in();
    next_cyc();
    @(negedge clk);
    chk("mcyc_wrap_lo", rdata, 0);
    chk("mcyc_wrap_hi", trap_rdata, 0);
    next_cyc();

    // Writing the low half while it sits at all-ones suppresses the carry.
    we = 1; waddr = 32'hB00; wdata = 32'hFFFF_FFFF;
    trap_we = 1; trap_waddr = 32'hB80; trap_wdata = 32'h7;
    next_cyc();
    clr_in();
    we = 1; waddr = 32'hB00; wdata = 32'h10;
    next_cyc();
    clr_in();
    @(negedge clk);
    chk("mcyc_nocarry_lo", rdata, 32'h10);
    chk("mcyc_nocarry_hi", trap_rdata, 7);
    next_cyc();

    // minstret: three pulses over ten cycles, then a dropped write to the read-only alias.
    raddr = 32'hC02; trap_raddr = 32'hC82;
    for (int i = 0; i < 10; i++) begin
      instret_inc = (i == 1 || i == 4 || i == 8);
      next_cyc();
    end
    instret_inc = 0;
    @(negedge clk);
    chk("instret_3", rdata, 3);
    chk("instreth_0", trap_rdata, 0);
    next_cyc();
    we = 1; waddr = 32'hC02; wdata = 32'h55;
    @(negedge clk);
    chk("instret_ro_bypass", rdata, 3);
    next_cyc();
    clr_in();
    @(negedge clk);
    chk("instret_ro_kept", rdata, 3);
    next_cyc();

    // Written halves take no increment; the next retire carries.
    we = 1; waddr = 32'hB02; wdata = 32'hFFFF_FFFF;
    trap_we = 1; trap_waddr = 32'hB82; trap_wdata = 32'h1;
    instret_inc = 1;
    raddr = 32'hB02; trap_raddr = 32'hB82;
    next_cyc();
    clr_in();
    instret_inc = 1;
    @(negedge clk);
    chk("minstret_w_lo", rdata, 32'hFFFF_FFFF);
    chk("minstret_w_hi", trap_rdata, 1);
    next_cyc();
    instret_inc = 0;
    @(negedge clk);
    chk("minstret_carry_lo", rdata, 0);
    chk("minstret_carry_hi", trap_rdata, 2);
    next_cyc();
    @(negedge clk);
    chk("minstret_hold_lo", rdata, 0);
    next_cyc();

    // MIE set, then reset wins over concurrent writes.
    we = 1; waddr = 32'h300; wdata = 32'h8;
    next_cyc();
    clr_in();
    @(negedge clk);
    chk("gie_set", {31'd0, global_int_en}, 1);
    chk("mstatus_8", mstatus, 8);
    next_cyc();
    rst = 1;
    we = 1; waddr = 32'h300; wdata = 32'h8;
    trap_we = 1; trap_waddr = 32'h341; trap_wdata = 32'h5;
    instret_inc = 1;
    next_cyc();
    rst = 0;
    clr_in();
    raddr = 32'hB00; trap_raddr = 32'hB02;
    @(negedge clk);
    chk("mid_rst_gie", {31'd0, global_int_en}, 0);
    chk("mid_rst_mstatus", mstatus, 0);
    chk("mid_rst_mepc", mepc, 0);
    chk("mid_rst_mtvec", mtvec, MTVEC_RST);
    chk("mid_rst_mcycle", rdata, 0);
    chk("mid_rst_minstret", trap_rdata, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/csr_reg.md
Name: csr_reg

Overview:
- Machine-mode CSR file for tiny_riscv; the responder that serves the decode stage's CSR read requests.
- Also accepts the execute stage's CSR write-back and a priority write/read port used by the trap/interrupt controller.
- Holds the free-running cycle and retired-instruction counters.
- Exports trap-relevant state (mtvec, mepc, mstatus, global interrupt enable) to the controller.

Parameters:
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec
- MHARTID_VAL, 32'h0000_0000, constant returned by mhartid
- MISA_VAL, 32'h4000_0100, constant returned by misa (RV32I)

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- raddr_i  input  32  CSR read address from decode; only bits [11:0] decoded
- rdata_o  output  32  CSR read data to decode, combinational
- we_i  input  1  execute-stage CSR write enable
- waddr_i  input  32  execute-stage CSR write address; bits [11:0] decoded
- wdata_i  input  32  execute-stage CSR write data
- trap_we_i  input  1  trap-controller write enable
- trap_waddr_i  input  32  trap-controller write address
- trap_wdata_i  input  32  trap-controller write data
- trap_raddr_i  input  32  trap-controller read address
- trap_rdata_o  output  32  trap-controller read data, combinational
- instret_inc_i  input  1  one instruction retired this cycle
- mtvec_o  output  32  current mtvec
- mepc_o  output  32  current mepc
- mstatus_o  output  32  current mstatus
- global_int_en_o  output  1  mstatus[3] (MIE)

Behaviour:
- Implemented CSRs, read/write:
  - mstatus 0x300, mie 0x304, mtvec 0x305
  - mscratch 0x340, mepc 0x341, mcause 0x342
  - mcycle 0xB00, mcycleh 0xB80, minstret 0xB02, minstreth 0xB82
- Read-only CSRs:
  - cycle 0xC00 / cycleh 0xC80 alias mcycle / mcycleh
  - instret 0xC02 / instreth 0xC82 alias minstret / minstreth
  - misa 0x301 = MISA_VAL, mhartid 0xF14 = MHARTID_VAL
- Address decode uses bits [11:0] only; bits [31:12] ignored on all address ports.
- Unimplemented addresses read 0; writes to them are dropped.
- Writes to read-only addresses are dropped silently; no exception.
- Reset: on posedge clk with rst=1:
  - mtvec <= MTVEC_RESET; every other register <= 0
  - mstatus_o = 0, mepc_o = 0, global_int_en_o = 0, mtvec_o = MTVEC_RESET in the following cycle
  - Writes and increments presented during a reset cycle are lost.
- Writes: registered; the new value is visible on the state outputs one cycle after the write cycle.
- Read ports: zero latency, combinational from the addresses.
- Read bypass, both read ports:
  - If a write enable is high and its address matches the read address in the same cycle, rdata returns that write's data.
  - When both writes match, trap data is returned.
  - Bypass applies only to writable addresses.
  - Counter reads without a same-cycle write return the registered value, not value+1.
- Simultaneous writes:
  - Same address: the trap write wins; the execute write is discarded.
  - Different addresses: both take effect.
- mcycle (64-bit, {mcycleh, mcycle}):
  - Increments by 1 every cycle rst=0.
  - Low-half wrap 0xFFFF_FFFF -> 0 carries into mcycleh; full 64-bit wrap to 0.
  - A write to one half replaces that half for that cycle, with no increment applied to it.
  - The unwritten half still updates normally, except that no carry is generated from a written low half.
- minstret (64-bit): same rules as mcycle, but increments only when instret_inc_i=1.
- mstatus: all 32 bits are storage; global_int_en_o = mstatus[3] continuously.
- mtvec_o, mepc_o, mstatus_o: direct register outputs.
- Mid-operation reset: counters and all CSRs return to reset values regardless of pending writes.

Test Plan:
- Reset, then read 0xB00 on consecutive cycles -> rdata_o 0, 1, 2...; read 0x301 -> 0x4000_0100; read 0xF14 -> 0; read 0x7C0 -> 0.
- we_i=1, waddr_i=0x305, wdata_i=0x8000_0100, raddr_i=0x305 same cycle -> rdata_o=0x8000_0100 immediately; mtvec_o=0x8000_0100 next cycle.
- Same-cycle writes to 0x341: we_i data 0x1111_1111, trap_we_i data 0x2222_2222 -> mepc_o=0x2222_2222 next cycle; writes to 0x300 and 0x342 together -> both updated.
- Write mcycle=0xFFFF_FFFE, mcycleh=5 in one cycle -> next cycles read {5,0xFFFF_FFFE}, then {5,0xFFFF_FFFF}, then {6,0}.
- Pulse instret_inc_i 3 times over 10 cycles -> 0xC02 reads 3; write 0xC02=0x55 -> ignored, still 3.
- Write mstatus=0x8 -> global_int_en_o=1 next cycle; assert rst with a concurrent write to 0x300 -> global_int_en_o=0 and mstatus_o=0 after the reset cycle.
